// File: rtl/timer_input_ctrl_param.sv
// timer_input_ctrl_param: keypad front-end for the microwave timer.
// Registers the raw key lines, picks the highest pressed key, debounces the
// press and the release, and shifts every accepted digit into an N-digit BCD
// entry register. In run mode a programmable divider produces the countdown
// tick on pgt_1Hz; in entry mode pgt_1Hz mirrors key_strobe.
// Optional build macro: TIMER_AUTOREPEAT_EN (auto-repeat of a held key).
module timer_input_ctrl_param #(
  parameter int DIGITS          = 4,
  parameter int DIV_RATIO       = 100,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_CYCLES   = 50
) (
  input  logic                        clock,
  input  logic                        clear_n,
  input  logic [9:0]                  keypad,
  input  logic                        enable_n,
  output logic [3:0]                  D,
  output logic                        load_n,
  output logic                        pgt_1Hz,
  output logic                        key_strobe,
  output logic [4*DIGITS-1:0]         digits_bcd,
  output logic [$clog2(DIGITS+1)-1:0] digit_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(DIV_RATIO);
  localparam int DCW   = $clog2(DIGITS + 1);

  // reject illegal parameter values at elaboration
  if (DIGITS < 1 || DIV_RATIO < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("timer_input_ctrl_param: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t             state, state_nx;
  logic [9:0]         kp_q;
  logic [3:0]         enc, code, code_nx;
  logic               valid;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               take;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [4*DIGITS-1:0] shifted;

`ifdef TIMER_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [RPT_W-1:0]   rpt, rpt_nx;
`endif

  // priority encoder on the registered keys: the highest index wins
  always_comb begin
    enc = 4'd0;
    for (int i = 0; i < 10; i++)
      if (kp_q[i]) enc = 4'(i);
  end

  assign valid  = |kp_q;
  assign load_n = (state != HELD);
  assign tick   = (div_cnt == DIV_W'(DIV_RATIO - 1));

  // entry register after accepting code_nx; a single digit is just replaced
  if (DIGITS == 1) begin : g_one
    assign shifted = code_nx;
  end else begin : g_many
    assign shifted = {digits_bcd[4*DIGITS-5:0], code_nx};
  end

  // next-state logic: debounce press, hold, debounce release
  always_comb begin
    state_nx = state;
    code_nx  = code;
    cnt_nx   = cnt;
    take     = 1'b0;
`ifdef TIMER_AUTOREPEAT_EN
    rpt_nx   = '0;
`endif
    case (state)
      IDLE: begin
        if (valid && !enable_n) begin
          code_nx = enc;
          if (DEBOUNCE_CYCLES == 1) begin
            take     = 1'b1;
            state_nx = HELD;
            cnt_nx   = '0;
          end else begin
            state_nx = DEBOUNCE;
            cnt_nx   = CNT_W'(1);
          end
        end
      end
      DEBOUNCE: begin
        if (enable_n || !valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          if (enc == code) begin
            cnt_nx = cnt + CNT_W'(1);
          end else begin
            code_nx = enc;
            cnt_nx  = CNT_W'(1);
          end
          if (cnt_nx == CNT_W'(DEBOUNCE_CYCLES)) begin
            take     = 1'b1;
            state_nx = HELD;
            cnt_nx   = '0;
          end
        end
      end
      HELD: begin
        // cnt counts consecutive released cycles; any key restarts it
        if (enable_n) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (valid) begin
          cnt_nx = '0;
`ifdef TIMER_AUTOREPEAT_EN
          if (enc == code) begin
            if (rpt == RPT_W'(REPEAT_CYCLES - 1)) take = 1'b1;
            else rpt_nx = rpt + RPT_W'(1);
          end
`endif
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FSM state, input register and debounce bookkeeping
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state <= IDLE;
      kp_q  <= '0;
      code  <= '0;
      cnt   <= '0;
`ifdef TIMER_AUTOREPEAT_EN
      rpt   <= '0;
`endif
    end else begin
      state <= state_nx;
      kp_q  <= keypad;
      code  <= code_nx;
      cnt   <= cnt_nx;
`ifdef TIMER_AUTOREPEAT_EN
      rpt   <= rpt_nx;
`endif
    end
  end

  // accepted digit: update D, shift the entry register, pulse the strobe
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      D           <= '0;
      key_strobe  <= 1'b0;
      digits_bcd  <= '0;
      digit_count <= '0;
    end else begin
      key_strobe <= take;
      if (take) begin
        D          <= code_nx;
        digits_bcd <= shifted;
        if (digit_count != DCW'(DIGITS)) digit_count <= digit_count + DCW'(1);
      end
    end
  end

  // run-mode divider, held at zero in entry mode; registered pgt_1Hz select
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      div_cnt <= '0;
      pgt_1Hz <= 1'b0;
    end else begin
      if (!enable_n)  div_cnt <= '0;
      else if (tick)  div_cnt <= '0;
      else            div_cnt <= div_cnt + DIV_W'(1);
      pgt_1Hz <= enable_n ? tick : take;
    end
  end

endmodule
